// File: rtl/packet_checker_pkg.sv
// rtl/packet_checker_pkg.sv - shared types, constants and helpers for packet_checker
//
// Contents:
//   state_e        : checker FSM states (compare, drain reference side, drain received side)
//   BEAT_IDX_WIDTH : width of the per-packet beat index and first_err_beat capture
//   sat_inc        : increment that sticks at the all-ones value of a given width
package packet_checker_pkg;

  typedef enum logic [1:0] {
    ST_CHECK      = 2'd0,
    ST_DRAIN_FIFO = 2'd1,
    ST_DRAIN_IN   = 2'd2
  } state_e;

  localparam int BEAT_IDX_WIDTH = 16;

  // Operates on a 64-bit container so one helper serves every counter width;
  // the caller truncates the result back to its own width.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] maxv;
    maxv = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    return (v >= maxv) ? maxv : (v + 64'd1);
  endfunction

endpackage

// File: rtl/keep_masked_compare.sv
// rtl/keep_masked_compare.sv - combinational beat comparator with optional TKEEP byte masking
//
// Ports:
//   in_data_i / in_keep_i   : received beat
//   exp_data_i / exp_keep_i : expected beat
//   mismatch_o              : 1 when the beats differ under the selected compare mode
module keep_masked_compare #(
  parameter int DATA_WIDTH = 512,
  parameter bit CHECK_KEEP = 1'b1,
  localparam int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic [KEEP_WIDTH-1:0] in_keep_i,
  input  logic [DATA_WIDTH-1:0] exp_data_i,
  input  logic [KEEP_WIDTH-1:0] exp_keep_i,
  output logic                  mismatch_o
);

  if (CHECK_KEEP) begin : g_masked
    // Keep vectors must match exactly, so the received keep alone selects the
    // lanes whose data is compared.
    always_comb begin
      mismatch_o = (in_keep_i != exp_keep_i);
      for (int i = 0; i < KEEP_WIDTH; i++) begin
        if (in_keep_i[i] && (in_data_i[i*8 +: 8] != exp_data_i[i*8 +: 8])) begin
          mismatch_o = 1'b1;
        end
      end
    end
  end else begin : g_full
    logic unused_keep;
    assign unused_keep = ^{in_keep_i, exp_keep_i};
    assign mismatch_o  = (in_data_i != exp_data_i);
  end

endmodule

// File: rtl/packet_checker.sv
// rtl/packet_checker.sv - received-vs-reference stream checker with framing resync and status counters
//
// Ports:
//   clk, resetn          : clock, asynchronous active-low reset
//   clear                : synchronous clear of counters, sticky flag and first-error captures
//   AXIS_IN_*            : received packet stream (TREADY is an output)
//   AXIS_FIFO_*          : expected-data stream (TREADY is an output)
//   error, packet_rcvd   : registered one-cycle strobes
//   error_sticky         : set on first error, held until clear
//   packet_count, bad_packet_count, error_count : saturating status counters
//   first_err_pkt, first_err_beat                : location of the first error since reset/clear
module packet_checker
  import packet_checker_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  localparam int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int CNT_WIDTH  = 32,
  parameter bit CHECK_KEEP = 1'b1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      clear,
  input  logic [DATA_WIDTH-1:0]     AXIS_IN_TDATA,
  input  logic [KEEP_WIDTH-1:0]     AXIS_IN_TKEEP,
  input  logic                      AXIS_IN_TLAST,
  input  logic                      AXIS_IN_TVALID,
  output logic                      AXIS_IN_TREADY,
  input  logic [DATA_WIDTH-1:0]     AXIS_FIFO_TDATA,
  input  logic [KEEP_WIDTH-1:0]     AXIS_FIFO_TKEEP,
  input  logic                      AXIS_FIFO_TLAST,
  input  logic                      AXIS_FIFO_TVALID,
  output logic                      AXIS_FIFO_TREADY,
  output logic                      error,
  output logic                      packet_rcvd,
  output logic                      error_sticky,
  output logic [CNT_WIDTH-1:0]      packet_count,
  output logic [CNT_WIDTH-1:0]      bad_packet_count,
  output logic [CNT_WIDTH-1:0]      error_count,
  output logic [CNT_WIDTH-1:0]      first_err_pkt,
  output logic [BEAT_IDX_WIDTH-1:0] first_err_beat
);

  state_e                    state_q, state_d;
  logic [BEAT_IDX_WIDTH-1:0] beat_idx_q, beat_idx_d;
  logic                      pkt_err_q, pkt_err_d;
  logic                      error_q, packet_rcvd_q;
  logic                      sticky_q, sticky_d;
  logic [CNT_WIDTH-1:0]      pkt_cnt_q, pkt_cnt_d;
  logic [CNT_WIDTH-1:0]      bad_cnt_q, bad_cnt_d;
  logic [CNT_WIDTH-1:0]      err_cnt_q, err_cnt_d;
  logic [CNT_WIDTH-1:0]      first_pkt_q, first_pkt_d;
  logic [BEAT_IDX_WIDTH-1:0] first_beat_q, first_beat_d;

  logic in_ready, fifo_ready;
  logic in_hs, fifo_hs;
  logic mismatch;
  logic check_beat, data_err, frame_err, any_err, in_last_hs;

  // Ready depends only on state and the valids, never on the handshakes, so
  // there is no combinational loop through the handshake terms.
  always_comb begin
    in_ready   = 1'b0;
    fifo_ready = 1'b0;
    case (state_q)
      ST_CHECK: begin
        in_ready   = AXIS_FIFO_TVALID;
        fifo_ready = AXIS_IN_TVALID & AXIS_FIFO_TVALID;
      end
      ST_DRAIN_FIFO: fifo_ready = 1'b1;
      ST_DRAIN_IN:   in_ready   = 1'b1;
      default: ;
    endcase
  end

  // Readies are forced low while reset is held so nothing is consumed.
  assign AXIS_IN_TREADY   = in_ready & resetn;
  assign AXIS_FIFO_TREADY = fifo_ready & resetn;
  assign in_hs   = AXIS_IN_TVALID & AXIS_IN_TREADY;
  assign fifo_hs = AXIS_FIFO_TVALID & AXIS_FIFO_TREADY;

  keep_masked_compare #(
    .DATA_WIDTH (DATA_WIDTH),
    .CHECK_KEEP (CHECK_KEEP)
  ) u_cmp (
    .in_data_i  (AXIS_IN_TDATA),
    .in_keep_i  (AXIS_IN_TKEEP),
    .exp_data_i (AXIS_FIFO_TDATA),
    .exp_keep_i (AXIS_FIFO_TKEEP),
    .mismatch_o (mismatch)
  );

  assign check_beat = (state_q == ST_CHECK) & in_hs;
  assign data_err   = check_beat & mismatch;
  assign frame_err  = check_beat & (AXIS_IN_TLAST != AXIS_FIFO_TLAST);
  assign any_err    = data_err | frame_err;
  assign in_last_hs = in_hs & AXIS_IN_TLAST;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CHECK: begin
        if (frame_err) begin
          state_d = AXIS_IN_TLAST ? ST_DRAIN_FIFO : ST_DRAIN_IN;
        end
      end
      ST_DRAIN_FIFO: if (fifo_hs && AXIS_FIFO_TLAST) state_d = ST_CHECK;
      ST_DRAIN_IN:   if (in_last_hs)                 state_d = ST_CHECK;
      default:       state_d = ST_CHECK;
    endcase
  end

  always_comb begin
    beat_idx_d   = beat_idx_q;
    pkt_err_d    = pkt_err_q;
    sticky_d     = sticky_q;
    pkt_cnt_d    = pkt_cnt_q;
    bad_cnt_d    = bad_cnt_q;
    err_cnt_d    = err_cnt_q;
    first_pkt_d  = first_pkt_q;
    first_beat_d = first_beat_q;

    // Beat index and per-packet flag track the stream and ignore clear.
    if (in_hs) begin
      beat_idx_d = AXIS_IN_TLAST ? '0
                 : BEAT_IDX_WIDTH'(sat_inc(64'(beat_idx_q), BEAT_IDX_WIDTH));
    end
    if (in_last_hs) begin
      pkt_err_d = 1'b0;
    end else if (any_err) begin
      pkt_err_d = 1'b1;
    end

    if (clear) begin
      sticky_d     = 1'b0;
      pkt_cnt_d    = '0;
      bad_cnt_d    = '0;
      err_cnt_d    = '0;
      first_pkt_d  = '0;
      first_beat_d = '0;
    end else begin
      if (in_last_hs) begin
        pkt_cnt_d = CNT_WIDTH'(sat_inc(64'(pkt_cnt_q), CNT_WIDTH));
        if (pkt_err_q || any_err) begin
          bad_cnt_d = CNT_WIDTH'(sat_inc(64'(bad_cnt_q), CNT_WIDTH));
        end
      end
      // A data and a framing error on the same beat count as two errors.
      if (data_err && frame_err) begin
        err_cnt_d = CNT_WIDTH'(sat_inc(sat_inc(64'(err_cnt_q), CNT_WIDTH), CNT_WIDTH));
      end else if (any_err) begin
        err_cnt_d = CNT_WIDTH'(sat_inc(64'(err_cnt_q), CNT_WIDTH));
      end
      if (any_err && !sticky_q) begin
        sticky_d     = 1'b1;
        first_pkt_d  = pkt_cnt_q;
        first_beat_d = beat_idx_q;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_CHECK;
      beat_idx_q    <= '0;
      pkt_err_q     <= 1'b0;
      error_q       <= 1'b0;
      packet_rcvd_q <= 1'b0;
      sticky_q      <= 1'b0;
      pkt_cnt_q     <= '0;
      bad_cnt_q     <= '0;
      err_cnt_q     <= '0;
      first_pkt_q   <= '0;
      first_beat_q  <= '0;
    end else begin
      state_q       <= state_d;
      beat_idx_q    <= beat_idx_d;
      pkt_err_q     <= pkt_err_d;
      error_q       <= any_err;
      packet_rcvd_q <= in_last_hs;
      sticky_q      <= sticky_d;
      pkt_cnt_q     <= pkt_cnt_d;
      bad_cnt_q     <= bad_cnt_d;
      err_cnt_q     <= err_cnt_d;
      first_pkt_q   <= first_pkt_d;
      first_beat_q  <= first_beat_d;
    end
  end

  assign error            = error_q;
  assign packet_rcvd      = packet_rcvd_q;
  assign error_sticky     = sticky_q;
  assign packet_count     = pkt_cnt_q;
  assign bad_packet_count = bad_cnt_q;
  assign error_count      = err_cnt_q;
  assign first_err_pkt    = first_pkt_q;
  assign first_err_beat   = first_beat_q;

endmodule

// File: tb/tb_packet_checker.sv
// tb/tb_packet_checker.sv - directed self-checking bench for packet_checker
module tb_packet_checker;

  localparam int DW = 32;
  localparam int KW = DW / 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          clear = 1'b0;
  logic [DW-1:0] in_tdata = '0;
  logic [KW-1:0] in_tkeep = '0;
  logic          in_tlast = 1'b0;
  logic          in_tvalid = 1'b0;
  logic [DW-1:0] f_tdata = '0;
  logic [KW-1:0] f_tkeep = '0;
  logic          f_tlast = 1'b0;
  logic          f_tvalid = 1'b0;

  logic        a_in_tready, a_f_tready, a_error, a_pkt, a_sticky;
  logic [31:0] a_pcnt, a_bcnt, a_ecnt, a_fpkt;
  logic [15:0] a_fbeat;
  logic        b_in_tready, b_f_tready, b_error, b_pkt, b_sticky;
  logic [31:0] b_pcnt, b_bcnt, b_ecnt, b_fpkt;
  logic [15:0] b_fbeat;
  logic        c_in_tready, c_f_tready, c_error, c_pkt, c_sticky;
  logic [3:0]  c_pcnt, c_bcnt, c_ecnt, c_fpkt;
  logic [15:0] c_fbeat;

  int checks = 0;
  int errors = 0;
  int err_strobes = 0;
  int pkt_strobes = 0;
  int es0, ps0;

  beat_t inq[$];
  beat_t fq[$];

  always #5 clk = ~clk;

  packet_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(32), .CHECK_KEEP(1'b1)) dut_a (
    .clk(clk), .resetn(resetn), .clear(clear),
    .AXIS_IN_TDATA(in_tdata), .AXIS_IN_TKEEP(in_tkeep), .AXIS_IN_TLAST(in_tlast),
    .AXIS_IN_TVALID(in_tvalid), .AXIS_IN_TREADY(a_in_tready),
    .AXIS_FIFO_TDATA(f_tdata), .AXIS_FIFO_TKEEP(f_tkeep), .AXIS_FIFO_TLAST(f_tlast),
    .AXIS_FIFO_TVALID(f_tvalid), .AXIS_FIFO_TREADY(a_f_tready),
    .error(a_error), .packet_rcvd(a_pkt), .error_sticky(a_sticky),
    .packet_count(a_pcnt), .bad_packet_count(a_bcnt), .error_count(a_ecnt),
    .first_err_pkt(a_fpkt), .first_err_beat(a_fbeat));

  packet_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(32), .CHECK_KEEP(1'b0)) dut_b (
    .clk(clk), .resetn(resetn), .clear(clear),
    .AXIS_IN_TDATA(in_tdata), .AXIS_IN_TKEEP(in_tkeep), .AXIS_IN_TLAST(in_tlast),
    .AXIS_IN_TVALID(in_tvalid), .AXIS_IN_TREADY(b_in_tready),
    .AXIS_FIFO_TDATA(f_tdata), .AXIS_FIFO_TKEEP(f_tkeep), .AXIS_FIFO_TLAST(f_tlast),
    .AXIS_FIFO_TVALID(f_tvalid), .AXIS_FIFO_TREADY(b_f_tready),
    .error(b_error), .packet_rcvd(b_pkt), .error_sticky(b_sticky),
    .packet_count(b_pcnt), .bad_packet_count(b_bcnt), .error_count(b_ecnt),
    .first_err_pkt(b_fpkt), .first_err_beat(b_fbeat));

  packet_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(4), .CHECK_KEEP(1'b1)) dut_c (
    .clk(clk), .resetn(resetn), .clear(clear),
    .AXIS_IN_TDATA(in_tdata), .AXIS_IN_TKEEP(in_tkeep), .AXIS_IN_TLAST(in_tlast),
    .AXIS_IN_TVALID(in_tvalid), .AXIS_IN_TREADY(c_in_tready),
    .AXIS_FIFO_TDATA(f_tdata), .AXIS_FIFO_TKEEP(f_tkeep), .AXIS_FIFO_TLAST(f_tlast),
    .AXIS_FIFO_TVALID(f_tvalid), .AXIS_FIFO_TREADY(c_f_tready),
    .error(c_error), .packet_rcvd(c_pkt), .error_sticky(c_sticky),
    .packet_count(c_pcnt), .bad_packet_count(c_bcnt), .error_count(c_ecnt),
    .first_err_pkt(c_fpkt), .first_err_beat(c_fbeat));

  always @(negedge clk) begin
    if (a_error) err_strobes++;
    if (a_pkt)   pkt_strobes++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int base, input int i);
    return DW'(32'hA500_0000 | ((base & 32'hFF) << 8) | (i & 32'hFF));
  endfunction

  task automatic push_in(input int n, input int base);
    for (int i = 0; i < n; i++) inq.push_back('{d: pat(base, i), k: '1, l: (i == n - 1)});
  endtask

  task automatic push_fifo(input int n, input int base);
    for (int i = 0; i < n; i++) fq.push_back('{d: pat(base, i), k: '1, l: (i == n - 1)});
  endtask

  task automatic push_both(input int n, input int base);
    push_in(n, base);
    push_fifo(n, base);
  endtask

  task automatic mod_in(input int idx, input logic [DW-1:0] xmask, input logic [KW-1:0] keep);
    beat_t b;
    b = inq[idx];
    b.d = b.d ^ xmask;
    b.k = keep;
    inq[idx] = b;
  endtask

  task automatic mod_fifo(input int idx, input logic [KW-1:0] keep);
    beat_t b;
    b = fq[idx];
    b.k = keep;
    fq[idx] = b;
  endtask

  // Presents queue heads each cycle and pops on handshake; ends when both drain.
  task automatic run();
    int cyc;
    bit ih, fh;
    cyc = 0;
    while ((inq.size() != 0 || fq.size() != 0) && cyc < 500) begin
      @(negedge clk);
      in_tvalid = (inq.size() != 0);
      if (in_tvalid) begin
        in_tdata = inq[0].d; in_tkeep = inq[0].k; in_tlast = inq[0].l;
      end
      f_tvalid = (fq.size() != 0);
      if (f_tvalid) begin
        f_tdata = fq[0].d; f_tkeep = fq[0].k; f_tlast = fq[0].l;
      end
      #1;
      ih = in_tvalid & a_in_tready;
      fh = f_tvalid & a_f_tready;
      @(posedge clk);
      if (ih) void'(inq.pop_front());
      if (fh) void'(fq.pop_front());
      cyc++;
    end
    chk("stream_drained", 64'((inq.size() == 0) && (fq.size() == 0)), 64'd1);
    inq.delete();
    fq.delete();
    @(negedge clk);
    in_tvalid = 1'b0;
    f_tvalid  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    es0 = err_strobes;
    ps0 = pkt_strobes;
  endtask

  initial begin
    // Reset: readies held low even with both valids asserted.
    in_tvalid = 1'b1;
    f_tvalid  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_tready", 64'(a_in_tready), 64'd0);
    chk("rst_fifo_tready", 64'(a_f_tready), 64'd0);
    chk("rst_pkt_cnt", 64'(a_pcnt), 64'd0);
    chk("rst_err_cnt", 64'(a_ecnt), 64'd0);
    chk("rst_sticky", 64'(a_sticky), 64'd0);
    chk("rst_error", 64'(a_error), 64'd0);
    in_tvalid = 1'b0;
    f_tvalid  = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    es0 = err_strobes;
    ps0 = pkt_strobes;

    // 10 clean packets of 4 beats.
    for (int p = 0; p < 10; p++) push_both(4, p);
    run();
    chk("clean_pkt_cnt", 64'(a_pcnt), 64'd10);
    chk("clean_err_cnt", 64'(a_ecnt), 64'd0);
    chk("clean_bad_cnt", 64'(a_bcnt), 64'd0);
    chk("clean_err_strobes", 64'(err_strobes - es0), 64'd0);
    chk("clean_pkt_strobes", 64'(pkt_strobes - ps0), 64'd10);
    chk("clean_first_pkt", 64'(a_fpkt), 64'd0);
    chk("clean_first_beat", 64'(a_fbeat), 64'd0);
    chk("clean_sticky", 64'(a_sticky), 64'd0);
    chk("clean_c_pkt_cnt", 64'(c_pcnt), 64'd10);

    // Packet index 2, beat 2: byte 1 flipped in a kept lane.
    do_clear();
    chk("clear_pkt_cnt", 64'(a_pcnt), 64'd0);
    for (int p = 0; p < 4; p++) push_both(4, p);
    mod_in(2*4 + 2, 32'h0000_FF00, 4'hF);
    run();
    chk("flip_err_strobes", 64'(err_strobes - es0), 64'd1);
    chk("flip_err_cnt", 64'(a_ecnt), 64'd1);
    chk("flip_bad_cnt", 64'(a_bcnt), 64'd1);
    chk("flip_first_pkt", 64'(a_fpkt), 64'd2);
    chk("flip_first_beat", 64'(a_fbeat), 64'd2);
    chk("flip_pkt_cnt", 64'(a_pcnt), 64'd4);
    chk("flip_sticky", 64'(a_sticky), 64'd1);

    // Differing byte in a lane with TKEEP=0 on both sides.
    do_clear();
    push_both(2, 7);
    mod_in(0, 32'hFF00_0000, 4'b0111);
    mod_fifo(0, 4'b0111);
    run();
    chk("mask_a_err_cnt", 64'(a_ecnt), 64'd0);
    chk("mask_a_sticky", 64'(a_sticky), 64'd0);
    chk("mask_b_err_cnt", 64'(b_ecnt), 64'd1);

    // IN 3 beats vs FIFO 5 beats, then a matched packet.
    do_clear();
    push_in(3, 1);
    push_fifo(5, 1);
    push_both(4, 2);
    run();
    chk("shortin_err_cnt", 64'(a_ecnt), 64'd1);
    chk("shortin_pkt_cnt", 64'(a_pcnt), 64'd2);
    chk("shortin_bad_cnt", 64'(a_bcnt), 64'd1);
    chk("shortin_first_beat", 64'(a_fbeat), 64'd2);

    // IN 5 beats vs FIFO 2 beats, then a matched packet.
    do_clear();
    push_in(5, 3);
    push_fifo(2, 3);
    run();
    chk("longin_pkt_strobes", 64'(pkt_strobes - ps0), 64'd1);
    chk("longin_pkt_cnt", 64'(a_pcnt), 64'd1);
    chk("longin_err_cnt", 64'(a_ecnt), 64'd1);
    chk("longin_first_beat", 64'(a_fbeat), 64'd1);
    push_both(2, 4);
    run();
    chk("longin_after_pkt_cnt", 64'(a_pcnt), 64'd2);
    chk("longin_after_err_cnt", 64'(a_ecnt), 64'd1);

    // Two errors, clear, then one clean packet and one error.
    do_clear();
    push_both(4, 5);
    mod_in(1, 32'h0000_0001, 4'hF);
    mod_in(3, 32'h0000_0001, 4'hF);
    run();
    chk("pre_clear_err_cnt", 64'(a_ecnt), 64'd2);
    chk("pre_clear_first_beat", 64'(a_fbeat), 64'd1);
    do_clear();
    chk("post_clear_sticky", 64'(a_sticky), 64'd0);
    push_both(4, 6);
    push_both(4, 7);
    mod_in(4 + 3, 32'h0001_0000, 4'hF);
    run();
    chk("recap_err_cnt", 64'(a_ecnt), 64'd1);
    chk("recap_first_pkt", 64'(a_fpkt), 64'd1);
    chk("recap_first_beat", 64'(a_fbeat), 64'd3);
    chk("recap_bad_cnt", 64'(a_bcnt), 64'd1);

    // Framing and data error on the same beat count twice, strobe once.
    do_clear();
    push_in(1, 8);
    push_fifo(2, 8);
    mod_in(0, 32'h0000_0010, 4'hF);
    run();
    chk("dbl_err_cnt", 64'(a_ecnt), 64'd2);
    chk("dbl_err_strobes", 64'(err_strobes - es0), 64'd1);
    chk("dbl_bad_cnt", 64'(a_bcnt), 64'd1);

    // 20 bad single-beat packets: 4-bit counters saturate at 15.
    do_clear();
    for (int p = 0; p < 20; p++) begin
      push_both(1, p);
      mod_in(p, 32'h0000_0080, 4'hF);
    end
    run();
    chk("sat_a_bad_cnt", 64'(a_bcnt), 64'd20);
    chk("sat_c_bad_cnt", 64'(c_bcnt), 64'd15);
    chk("sat_c_err_cnt", 64'(c_ecnt), 64'd15);
    chk("sat_c_pkt_cnt", 64'(c_pcnt), 64'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
